// File: rtl/nd_reduce_pipe.sv
// Pipelined N-input NAND/AND/NOR/OR reduction with valid/ready flow control.
// Define ND_REDUCE_PIPE_CNT_EN to build the Z=0 output-transfer counter; otherwise CNT is tied to 0.
module nd_reduce_pipe #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 1
) (
  input  logic             CK,
  input  logic             RN,
  input  logic [WIDTH-1:0] A,
  input  logic [1:0]       MODE,
  input  logic             IVLD,
  output logic             IRDY,
  output logic             Z,
  output logic             OVLD,
  input  logic             ORDY,
  input  logic             CNTCLR,
  output logic [15:0]      CNT
);

  logic [STAGES-1:0] stg_vld;
  logic [STAGES-1:0] stg_res;
  logic [STAGES-1:0] stg_load;
  logic              gate_res;

  always_comb begin
    gate_res = 1'b0;
    case (MODE)
      2'b00:   gate_res = ~(&A);
      2'b01:   gate_res = &A;
      2'b10:   gate_res = ~(|A);
      default: gate_res = |A;
    endcase
  end

  // A stage may load when it, or any stage between it and the output, has room.
  always_comb begin : load_chain
    logic room;
    room     = ORDY;
    stg_load = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      room        = room | ~stg_vld[k];
      stg_load[k] = room;
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      stg_vld <= '0;
      stg_res <= '0;
    end else begin
      if (stg_load[0]) begin
        stg_vld[0] <= IVLD;
        stg_res[0] <= gate_res;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (stg_load[k]) begin
          stg_vld[k] <= stg_vld[k-1];
          stg_res[k] <= stg_res[k-1];
        end
      end
    end
  end

  assign IRDY = stg_load[0];
  assign Z    = stg_res[STAGES-1];
  assign OVLD = stg_vld[STAGES-1];

`ifdef ND_REDUCE_PIPE_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      cnt_q <= '0;
    end else if (CNTCLR) begin
      cnt_q <= '0;
    end else if (OVLD && ORDY && !Z && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign CNT = cnt_q;
`else
  logic unused_cntclr;

  assign unused_cntclr = CNTCLR;
  assign CNT           = '0;
`endif

endmodule

// File: tb/tb_nd_reduce_pipe.sv
// Self-checking bench for nd_reduce_pipe: four depths (1..4) share one stimulus stream,
// each checked against an item-level queue model of in-flight results.
module tb_nd_reduce_pipe;

  logic       CK;
  logic       RN;
  logic       ivld;
  logic       ordy;
  logic       cntclr;
  logic [7:0] a_in;
  logic [1:0] mode;
  logic [3:0] irdy;
  logic [3:0] z;
  logic [3:0] ovld;
  logic [15:0] cnt_w [4];

  int n_cmp = 0;
  int n_bad = 0;

  // Model: per DUT, an ordered list of in-flight items (head first) with stage position.
  int m_cnt [4];
  int m_pos [4][4];
  bit m_val [4][4];
  int m_ctr [4];
  bit e_irdy [4];
  bit e_ovld [4];

  nd_reduce_pipe #(.WIDTH(5), .STAGES(1)) u_s1 (
    .CK(CK), .RN(RN), .A(a_in[4:0]), .MODE(mode), .IVLD(ivld), .IRDY(irdy[0]),
    .Z(z[0]), .OVLD(ovld[0]), .ORDY(ordy), .CNTCLR(cntclr), .CNT(cnt_w[0]));
  nd_reduce_pipe #(.WIDTH(8), .STAGES(2)) u_s2 (
    .CK(CK), .RN(RN), .A(a_in), .MODE(mode), .IVLD(ivld), .IRDY(irdy[1]),
    .Z(z[1]), .OVLD(ovld[1]), .ORDY(ordy), .CNTCLR(cntclr), .CNT(cnt_w[1]));
  nd_reduce_pipe #(.WIDTH(8), .STAGES(3)) u_s3 (
    .CK(CK), .RN(RN), .A(a_in), .MODE(mode), .IVLD(ivld), .IRDY(irdy[2]),
    .Z(z[2]), .OVLD(ovld[2]), .ORDY(ordy), .CNTCLR(cntclr), .CNT(cnt_w[2]));
  nd_reduce_pipe #(.WIDTH(6), .STAGES(4)) u_s4 (
    .CK(CK), .RN(RN), .A(a_in[5:0]), .MODE(mode), .IVLD(ivld), .IRDY(irdy[3]),
    .Z(z[3]), .OVLD(ovld[3]), .ORDY(ordy), .CNTCLR(cntclr), .CNT(cnt_w[3]));

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int width_of(input int d);
    case (d)
      0:       return 5;
      3:       return 6;
      default: return 8;
    endcase
  endfunction

  function automatic bit ref_gate(input logic [7:0] a, input int w, input logic [1:0] md);
    int mask;
    int bits;
    mask = (1 << w) - 1;
    bits = int'(a) & mask;
    case (md)
      2'b00:   return bits != mask;
      2'b01:   return bits == mask;
      2'b10:   return bits == 0;
      default: return bits != 0;
    endcase
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 4; d++) begin
      m_cnt[d] = 0;
      m_ctr[d] = 0;
    end
  endtask

  // Apply inputs just after the falling edge, then compare outputs against the model.
  task automatic drive(input logic iv, input logic orv, input logic [7:0] av,
                       input logic [1:0] mv, input logic clr);
    ivld = iv; ordy = orv; a_in = av; mode = mv; cntclr = clr;
    #1;
    for (int d = 0; d < 4; d++) begin
      e_irdy[d] = orv || (m_cnt[d] < d + 1);
      e_ovld[d] = (m_cnt[d] > 0) && (m_pos[d][0] == d);
      chk($sformatf("s%0d_irdy", d + 1), int'(irdy[d]), int'(e_irdy[d]));
      chk($sformatf("s%0d_ovld", d + 1), int'(ovld[d]), int'(e_ovld[d]));
      if (e_ovld[d]) chk($sformatf("s%0d_z", d + 1), int'(z[d]), int'(m_val[d][0]));
      chk($sformatf("s%0d_cnt", d + 1), int'(cnt_w[d]), m_ctr[d]);
    end
  endtask

  // Advance the model across the rising edge, then move to the next falling edge.
  task automatic tick();
    for (int d = 0; d < 4; d++) begin
      int  s;
      int  lim;
      bit  out_x;
      bit  in_x;
      s     = d + 1;
      out_x = e_ovld[d] && ordy;
      in_x  = ivld && e_irdy[d];
`ifdef ND_REDUCE_PIPE_CNT_EN
      if (cntclr) m_ctr[d] = 0;
      else if (out_x && !m_val[d][0] && m_ctr[d] < 65535) m_ctr[d]++;
`endif
      lim = ordy ? s + 1 : s;
      for (int i = 0; i < m_cnt[d]; i++) begin
        if (m_pos[d][i] + 1 < lim) m_pos[d][i]++;
        lim = m_pos[d][i];
      end
      if (m_cnt[d] > 0 && m_pos[d][0] == s) begin
        for (int i = 1; i < m_cnt[d]; i++) begin
          m_pos[d][i-1] = m_pos[d][i];
          m_val[d][i-1] = m_val[d][i];
        end
        m_cnt[d]--;
      end
      if (in_x) begin
        m_pos[d][m_cnt[d]] = 0;
        m_val[d][m_cnt[d]] = ref_gate(a_in, width_of(d), mode);
        m_cnt[d]++;
      end
    end
    @(posedge CK);
    @(negedge CK);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      drive(1'b0, 1'b1, 8'h00, 2'b00, 1'b0);
      tick();
    end
  endtask

  task automatic rnd_cycles(input int n, input int ivld_pct, input int ordy_pct);
    repeat (n) begin
      drive(1'($urandom_range(0, 99) < ivld_pct), 1'($urandom_range(0, 99) < ordy_pct),
            8'($urandom), 2'($urandom), 1'($urandom_range(0, 63) == 0));
      tick();
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s_s%0d_ovld", tag, d + 1), int'(ovld[d]), 0);
      chk($sformatf("%s_s%0d_z", tag, d + 1), int'(z[d]), 0);
      chk($sformatf("%s_s%0d_cnt", tag, d + 1), int'(cnt_w[d]), 0);
      chk($sformatf("%s_s%0d_irdy", tag, d + 1), int'(irdy[d]), 1);
    end
  endtask

  logic [3:0] seq_exp;

  initial begin
    RN = 1'b0; ivld = 1'b0; ordy = 1'b0; cntclr = 1'b0; a_in = '0; mode = '0;
    model_clear();
    #1;
    chk_reset_vals("por");
    @(negedge CK);
    RN = 1'b1;

    // Single stage: all-ones NAND gives 0, then one-zero NAND gives 1; counter sees one Z=0.
    drive(1'b1, 1'b1, 8'hFF, 2'b00, 1'b0);
    chk("s1_first_ovld", int'(ovld[0]), 0);
    tick();
    drive(1'b1, 1'b1, 8'hFE, 2'b00, 1'b0);
    chk("s1_nand_ones_z", int'(z[0]), 0);
    chk("s1_nand_ones_ovld", int'(ovld[0]), 1);
    tick();
    drive(1'b0, 1'b1, 8'h00, 2'b00, 1'b0);
    chk("s1_nand_zero_z", int'(z[0]), 1);
`ifdef ND_REDUCE_PIPE_CNT_EN
    chk("s1_cnt_one", int'(cnt_w[0]), 1);
`else
    chk("s1_cnt_off", int'(cnt_w[0]), 0);
`endif
    tick();
    idle(5);

    // Three stages: four modes back to back on A=0; first result after three edges.
    seq_exp = 4'b0101;
    for (int i = 0; i < 8; i++) begin
      drive(1'(i < 4), 1'b1, 8'h00, 2'(i), 1'b0);
      if (i >= 3 && i < 7) begin
        chk("s3_seq_ovld", int'(ovld[2]), 1);
        chk("s3_seq_z", int'(z[2]), int'(seq_exp[i-3]));
      end else begin
        chk("s3_seq_gap", int'(ovld[2]), 0);
      end
      tick();
    end
    idle(3);

    // Two stages: fill, stall five cycles, then release in order.
    drive(1'b1, 1'b0, 8'h0F, 2'b01, 1'b0); tick();
    drive(1'b1, 1'b0, 8'hFF, 2'b01, 1'b0); tick();
    repeat (5) begin
      drive(1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
      chk("s2_stall_irdy", int'(irdy[1]), 0);
      chk("s2_stall_ovld", int'(ovld[1]), 1);
      chk("s2_stall_z", int'(z[1]), 0);
      tick();
    end
    drive(1'b0, 1'b1, 8'h00, 2'b00, 1'b0);
    chk("s2_rel_first_z", int'(z[1]), 0);
    tick();
    drive(1'b0, 1'b1, 8'h00, 2'b00, 1'b0);
    chk("s2_rel_second_z", int'(z[1]), 1);
    chk("s2_rel_irdy", int'(irdy[1]), 1);
    tick();
    drive(1'b0, 1'b1, 8'h00, 2'b00, 1'b0);
    chk("s2_rel_empty", int'(ovld[1]), 0);
    tick();
    idle(4);

    // Four stages: fill, then ten cycles of simultaneous in/out with no bubble.
    repeat (4) begin
      drive(1'b1, 1'b0, 8'($urandom), 2'($urandom), 1'b0);
      tick();
    end
    repeat (10) begin
      drive(1'b1, 1'b1, 8'($urandom), 2'($urandom), 1'b0);
      chk("s4_full_irdy", int'(irdy[3]), 1);
      chk("s4_full_ovld", int'(ovld[3]), 1);
      tick();
    end
    idle(6);

    rnd_cycles(1200, 70, 60);

    // Reset between edges with results in flight.
    repeat (3) begin
      drive(1'b1, 1'b0, 8'($urandom), 2'($urandom), 1'b0);
      tick();
    end
    ivld = 1'b0; cntclr = 1'b0;
    #2 RN = 1'b0;
    #1 chk_reset_vals("midrst");
    model_clear();
    #1 RN = 1'b1;
    @(negedge CK);
    for (int i = 0; i < 5; i++) begin
      drive(1'(i == 0), 1'b1, 8'h00, 2'b00, 1'b0);
      chk("post_rst_s3_ovld", int'(ovld[2]), int'(i == 3));
      tick();
    end

    rnd_cycles(1200, 60, 50);
    rnd_cycles(300, 80, 100);
    rnd_cycles(300, 100, 30);

`ifdef ND_REDUCE_PIPE_CNT_EN
    drive(1'b0, 1'b1, 8'h00, 2'b00, 1'b1); tick();
    idle(5);
    repeat (65545) begin
      drive(1'b1, 1'b1, 8'hFF, 2'b00, 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, 8'hFF, 2'b00, 1'b1);
    chk("cnt_sat_s1", int'(cnt_w[0]), 65535);
    chk("cnt_sat_s4", int'(cnt_w[3]), 65535);
    tick();
    drive(1'b0, 1'b1, 8'h00, 2'b00, 1'b0);
    chk("cnt_clr_wins_s1", int'(cnt_w[0]), 0);
    chk("cnt_clr_wins_s3", int'(cnt_w[2]), 0);
    tick();
`endif

    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nd_reduce_pipe.md
ND_REDUCE_PIPE -- requirements
Module: nd_reduce_pipe

Interface
REQ-001 Parameter WIDTH, default 5, number of gate inputs; legal range 2..32.
REQ-002 Parameter STAGES, default 1, pipeline register depth; legal range 1..4.
REQ-003 Port CK  input  1  clock; all state SHALL update on its rising edge.
REQ-004 Port RN  input  1  reset, asynchronous, active-low.
REQ-005 Port A  input  WIDTH  gate operand bits.
REQ-006 Port MODE  input  2  function select: 00 NAND, 01 AND, 10 NOR, 11 OR.
REQ-007 Port IVLD  input  1  A/MODE valid this cycle.
REQ-008 Port IRDY  output  1  block can accept A/MODE this cycle.
REQ-009 Port Z  output  1  registered gate result.
REQ-010 Port OVLD  output  1  Z valid.
REQ-011 Port ORDY  input  1  downstream accepts Z this cycle.
REQ-012 Port CNTCLR  input  1  synchronous clear of transfer counter.
REQ-013 Port CNT  output  16  count of output transfers with Z=0.

Function
REQ-014 Input transfer SHALL occur on a CK edge where IVLD=1 and IRDY=1; output transfer on an edge where OVLD=1 and ORDY=1.
REQ-015 Result SHALL be the MODE-selected reduction of all WIDTH bits of A, sampled at input transfer; MODE SHALL be captured per transfer, not global.
REQ-016 Pipeline SHALL be STAGES registers, each holding {result, valid}; Z/OVLD SHALL be driven from the last stage only.
REQ-017 Stage k SHALL load when it is empty or stage k+1 loads (last stage: when empty or ORDY=1); otherwise it SHALL hold.
REQ-018 IRDY SHALL equal the load condition of stage 0 (combinational from stage valids and ORDY).
REQ-019 With ORDY held 1, latency from input transfer to OVLD=1 SHALL be STAGES cycles; throughput one result per cycle.
REQ-020 Full pipeline with ORDY=0: IRDY=0, all stages hold, Z stable, no data lost or duplicated.
REQ-021 Full pipeline with ORDY=1 and IVLD=1 on the same edge: output and input transfer simultaneously; occupancy unchanged.
REQ-022 Results SHALL leave in input order; an empty stage SHALL never assert valid downstream.
REQ-023 CNT SHALL increment by 1 per output transfer with Z=0, saturate at 16'hFFFF, and clear to 0 on an edge with CNTCLR=1; CNTCLR SHALL win over a simultaneous increment.

Reset
REQ-024 RN=0 SHALL immediately clear all stage valids, stage results, and CNT to 0, regardless of CK.
REQ-025 During reset: OVLD=0, Z=0, CNT=0; IRDY SHALL be 1 (pipeline empty).
REQ-026 Reset mid-operation SHALL discard all in-flight results; first input transfer after RN release produces the next OVLD exactly STAGES cycles later.

Configuration
REQ-027 Macro ND_REDUCE_PIPE_CNT_EN: defined -> counter logic per REQ-023 compiled in.
REQ-028 Macro ND_REDUCE_PIPE_CNT_EN undefined -> no counter registers; CNT SHALL be constant 0, CNTCLR ignored; all other behaviour identical.

Verification
REQ-029 WIDTH=5, STAGES=1, ORDY=1: A=5'b11111 MODE=00 -> Z=0 one cycle later; A=5'b11110 MODE=00 -> Z=1; CNT=1.
REQ-030 WIDTH=8, STAGES=3: back-to-back MODE 00/01/10/11 with A=8'h00 -> Z sequence 1,0,1,0, first OVLD 3 cycles after first transfer, one per cycle after.
REQ-031 STAGES=2: fill with 2 results, ORDY=0 for 5 cycles -> IRDY=0, Z/OVLD stable; ORDY=1 -> both results emerge in order, IRDY=1 next cycle.
REQ-032 STAGES=4: pipeline full, IVLD=1 and ORDY=1 held for 10 cycles -> 10 transfers each side, no bubble, order preserved.
REQ-033 RN pulsed low between CK edges with 3 results in flight -> OVLD, Z, CNT drop to 0 immediately; no stale result appears after release.
REQ-034 CNT_EN defined: force 65 540 Z=0 transfers -> CNT=16'hFFFF; CNTCLR=1 with concurrent Z=0 transfer -> CNT=0. Undefined: CNT=0 throughout.
